// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - stream input and frame output bundle for tdm_demux4
interface tdm_demux4_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_sof;
  logic [WIDTH-1:0]   in_data;
  logic [4*WIDTH-1:0] out_data;
  logic               frame_valid;
  logic               locked;
  logic               sync_err;
  logic [7:0]         err_cnt;

  // Source of the slot stream, sink of the reassembled frames
  modport master (
    output in_valid, in_sof, in_data,
    input  out_data, frame_valid, locked, sync_err, err_cnt
  );

  // The demultiplexer itself
  modport slave (
    input  in_valid, in_sof, in_data,
    output out_data, frame_valid, locked, sync_err, err_cnt
  );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with HUNT/LOCKED frame sync
// Optional saturating sync-error counter enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   shadow0_q, shadow0_d;
  logic [WIDTH-1:0]   shadow1_q, shadow1_d;
  logic [WIDTH-1:0]   shadow2_q, shadow2_d;
  logic [4*WIDTH-1:0] out_data_q, out_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               sync_err_q, sync_err_d;

  // Next-state: slot tracking, shadow capture, frame commit and sync checks
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    shadow2_d     = shadow2_q;
    out_data_d    = out_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            shadow0_d = bus.in_data;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.in_sof) begin
            // An SOF mid-frame abandons the partial frame and restarts at slot 0
            sync_err_d = (slot_q != 2'd0);
            shadow0_d  = bus.in_data;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Slot 0 without SOF means alignment is lost; re-hunt
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            case (slot_q)
              2'd1: begin
                shadow1_d = bus.in_data;
                slot_d    = 2'd2;
              end
              2'd2: begin
                shadow2_d = bus.in_data;
                slot_d    = 2'd3;
              end
              default: begin
                out_data_d    = {bus.in_data, shadow2_q, shadow1_q, shadow0_q};
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      out_data_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      out_data_q    <= out_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count sync errors in step with the sync_err pulse, saturating at 255
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.out_data    = out_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer: the receive-side counterpart of the team's 4:1 channel mux. It takes a framed stream of one WIDTH-bit word per slot, tracks slot position with a 2-bit counter, and reassembles four channel words into a parallel frame. It sits between the pad-facing `ui_in` data path and the downstream per-channel logic. The block detects frame-sync loss and re-acquires lock through a HUNT state.

## Interface

Parameters:
- `WIDTH`, default 4: bits per channel word.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  `in_data` / `in_sof` are valid this cycle.
- `in_sof`  input  1  start of frame; marks the slot-0 word. Qualified by `in_valid`.
- `in_data`  input  WIDTH  channel word for the current slot.
- `out_data`  output  4*WIDTH  last complete frame, packed {ch3, ch2, ch1, ch0}.
- `frame_valid`  output  1  one-cycle pulse when `out_data` updates.
- `locked`  output  1  high in the LOCKED state.
- `sync_err`  output  1  one-cycle pulse on a frame-sync violation.
- `err_cnt`  output  8  saturating sync-error count; see Configuration.

## Operation

States: HUNT and LOCKED. Internal state is `slot[1:0]` plus a shadow register of three words (ch0..ch2).

HUNT:
- Words with `in_valid & ~in_sof` are discarded; no error is flagged.
- On `in_valid & in_sof`, the word is stored as shadow ch0, `slot` goes to 1, and the state goes to LOCKED.

LOCKED, on each `in_valid` cycle:
- **`slot != 0`, `in_sof` low:** store the word in `shadow[slot]`.
  - If `slot == 3`: load `out_data <= {in_data, shadow2, shadow1, shadow0}`, pulse `frame_valid`, and set `slot` to 0.
  - Otherwise: `slot` increments by 1.
- **`slot == 0`, `in_sof` high:** normal frame start. Store shadow ch0 and set `slot` to 1.
- **`slot != 0`, `in_sof` high (early SOF):**
  - Pulse `sync_err`.
  - Drop the partial frame; `out_data` is unchanged and there is no `frame_valid`.
  - Treat the word as slot 0: store shadow ch0, set `slot` to 1, stay in LOCKED.
- **`slot == 0`, `in_sof` low (missing SOF):** pulse `sync_err`, discard the word, go to HUNT.

General rules:
- When `in_valid` is low, nothing advances; state, slot and outputs hold. Gaps of any length are allowed mid-frame.
- `in_sof` without `in_valid` is ignored.
- `out_data` holds the last complete frame until the next one completes. It is never partially updated.
- `rst` high on any edge, including mid-frame, wins over all other inputs:
  - state goes to HUNT, `slot` to 0, shadow to 0;
  - `out_data` = 0, `frame_valid` = 0, `sync_err` = 0, `locked` = 0, `err_cnt` = 0.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Latency: the slot-3 word is accepted on edge N. `out_data` and `frame_valid` update on that same edge N, so they are visible in cycle N+1. `frame_valid` is high for exactly one cycle.
- `sync_err` is high the cycle after the offending word is accepted, for one cycle.
- `locked` follows the state register:
  - rises the cycle after the SOF in HUNT is accepted;
  - falls the cycle after a missing-SOF word is accepted.
- Maximum throughput is one frame per 4 cycles when `in_valid` is held high.
- Back-to-back frames need no idle cycle.

## Configuration

- `TDM_DEMUX_ERRCNT_EN` defined:
  - `err_cnt` is an 8-bit counter, incremented on each `sync_err` pulse.
  - It saturates at 255 and stays there until `rst`.
- Undefined: `err_cnt` is tied to 0 and the counter logic is not generated. All other behaviour is identical.

## Test plan

- **Lock and single frame:** after `rst`, send valid words (sof=1, 0x1), then 0x2, 0x3, 0x4.
  - `locked` rises after the first word.
  - `frame_valid` pulses once; `out_data` = 0x4321.
- **Gaps:** send the same frame with `in_valid` low for 3 cycles between each word → `out_data` = 0x4321, a single `frame_valid` pulse, no `sync_err`.
- **Early SOF:** send sof+0xA, 0xB, then sof+0x5, 0x6, 0x7, 0x8.
  - One `sync_err` pulse.
  - `frame_valid` pulses only once, with `out_data` = 0x8765.
  - `locked` stays high.
- **Missing SOF:** after a complete frame, send 0x9 with sof=0.
  - `sync_err` pulses and `locked` falls.
  - Following non-SOF words are ignored until an SOF arrives; `out_data` is unchanged.
- **Reset mid-frame:** assert `rst` after 2 words of a frame.
  - All outputs are 0 the next cycle.
  - A fresh 4-word frame 0xF, 0xE, 0xD, 0xC gives `out_data` = 0xCDEF.
- **With `TDM_DEMUX_ERRCNT_EN`:** force 300 missing-SOF errors → `err_cnt` = 255. `rst` → `err_cnt` = 0.
